// File: rtl/result_buffer.sv
// Elastic result queue between an execution unit and the CDB arbiter.
// Optional same-cycle forwarding into an empty buffer: RESULT_BUFFER_BYPASS_EN.
package result_buffer_pkg;
    typedef struct packed {
        logic cr0_lt;
        logic cr0_gt;
        logic cr0_eq;
        logic cr0_so;
        logic xer_so;
        logic xer_ov;
        logic xer_ca;
    } cond_exception_t;
endpackage

module result_buffer
    import result_buffer_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned RS_ID_WIDTH = 5
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [RS_ID_WIDTH-1:0]              in_rs_id,
    input  logic [4:0]                          in_result_reg_addr,
    input  logic [31:0]                         in_result,
    input  cond_exception_t                     in_cr0_xer,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [RS_ID_WIDTH-1:0]              out_rs_id,
    output logic [4:0]                          out_result_reg_addr,
    output logic [31:0]                         out_result,
    output cond_exception_t                     out_cr0_xer,
    output logic [$clog2(DEPTH+1)-1:0]          count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [RS_ID_WIDTH-1:0] rs_id;
        logic [4:0]             reg_addr;
        logic [31:0]            result;
        cond_exception_t        cr0_xer;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               in_ready_q, in_ready_d;

    entry_t             in_entry;
    entry_t             head;
    logic               bypass_c;
    logic               push_c;
    logic               pop_c;

    assign in_entry = '{rs_id: in_rs_id, reg_addr: in_result_reg_addr,
                        result: in_result, cr0_xer: in_cr0_xer};
    assign head     = mem_q[rptr_q];

`ifdef RESULT_BUFFER_BYPASS_EN
    assign bypass_c = (count_q == '0) && in_valid && out_ready && !flush;
`else
    assign bypass_c = 1'b0;
`endif

    // A forwarded beat is consumed by the CDB directly and never stored.
    assign push_c = in_valid && in_ready_q && !flush && !bypass_c;
    assign pop_c  = (count_q != '0) && out_ready && !flush;

    // Pointer, occupancy and ready next-state; flush overrides everything.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        in_ready_d = in_ready_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_c) wptr_d = wptr_q + PTR_W'(1);
            if (pop_c)  rptr_d = rptr_q + PTR_W'(1);
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
        in_ready_d = (count_d != CNT_W'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (push_c) begin
            mem_q[wptr_q] <= in_entry;
        end
    end

    assign in_ready            = in_ready_q;
    assign count               = count_q;
    assign out_valid           = bypass_c || ((count_q != '0) && !flush);
    assign out_rs_id           = bypass_c ? in_entry.rs_id    : head.rs_id;
    assign out_result_reg_addr = bypass_c ? in_entry.reg_addr : head.reg_addr;
    assign out_result          = bypass_c ? in_entry.result   : head.result;
    assign out_cr0_xer         = bypass_c ? in_entry.cr0_xer  : head.cr0_xer;

endmodule

// File: tb/tb_result_buffer.sv
// Directed and randomized bench for result_buffer against a queue-based model.
module tb_result_buffer;
    import result_buffer_pkg::*;

    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [4:0]      rs;
        logic [4:0]      addr;
        logic [31:0]     res;
        cond_exception_t cx;
    } ent_t;

    logic            clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [4:0]      in_rs_id, in_result_reg_addr, out_rs_id, out_result_reg_addr;
    logic [31:0]     in_result, out_result;
    cond_exception_t in_cr0_xer, out_cr0_xer;
    logic [2:0]      count;

    int n_checks = 0;
    int n_pass   = 0;

    ent_t q[$];
    logic m_bypass, m_in_ready;

    result_buffer #(.DEPTH(DEPTH), .RS_ID_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs_id(in_rs_id), .in_result_reg_addr(in_result_reg_addr),
        .in_result(in_result), .in_cr0_xer(in_cr0_xer),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs_id(out_rs_id), .out_result_reg_addr(out_result_reg_addr),
        .out_result(out_result), .out_cr0_xer(out_cr0_xer),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic ent_t mk(input logic [4:0] rs, input logic [4:0] addr,
                                input logic [31:0] res, input logic [6:0] cx);
        ent_t e;
        e.rs = rs; e.addr = addr; e.res = res; e.cx = cx;
        return e;
    endfunction

    function automatic ent_t obs_ent();
        return {out_rs_id, out_result_reg_addr, out_result, out_cr0_xer};
    endfunction

    function automatic ent_t in_ent();
        return {in_rs_id, in_result_reg_addr, in_result, in_cr0_xer};
    endfunction

    // Expected outputs from the queue contents and the current inputs.
    task automatic model_check();
        logic exp_valid;
        ent_t exp_e;
`ifdef RESULT_BUFFER_BYPASS_EN
        m_bypass = (q.size() == 0) && in_valid && out_ready && !flush;
`else
        m_bypass = 1'b0;
`endif
        m_in_ready = (q.size() != DEPTH);
        exp_valid  = m_bypass || ((q.size() != 0) && !flush);
        chk("m_count", 64'(count), 64'(q.size()));
        chk("m_in_ready", 64'(in_ready), 64'(m_in_ready));
        chk("m_out_valid", 64'(out_valid), 64'(exp_valid));
        chk("m_no_x", 64'($isunknown(obs_ent())), 64'(0));
        if (exp_valid) begin
            exp_e = m_bypass ? in_ent() : q[0];
            chk("m_head", 64'(obs_ent()), 64'(exp_e));
        end
    endtask

    task automatic set_in(input logic iv, input ent_t e, input logic ordy, input logic fl);
        @(negedge clk);
        in_valid = iv;
        {in_rs_id, in_result_reg_addr, in_result, in_cr0_xer} = e;
        out_ready = ordy;
        flush = fl;
        #1;
        model_check();
    endtask

    // Advance one edge and apply the FIFO rules to the model.
    task automatic tick();
        ent_t e;
        bit had;
        e = in_ent();
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            had = (q.size() != 0);
            if (had && out_ready) void'(q.pop_front());
            if (in_valid && m_in_ready && !m_bypass) q.push_back(e);
        end
    endtask

    initial begin
        ent_t idle;
        idle = '0;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_rs_id = '0; in_result_reg_addr = '0; in_result = '0; in_cr0_xer = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_storage", 64'(obs_ent()), 64'(0));
        @(negedge clk);
        rst = 1'b1;

        // Single push with back-pressure.
        set_in(1, mk(5'd3, 5'd7, 32'hDEADBEEF, 7'h15), 0, 0); tick();
        set_in(0, idle, 0, 0);
        chk("p1_valid", 64'(out_valid), 64'(1));
        chk("p1_result", 64'(out_result), 64'(32'hDEADBEEF));
        chk("p1_rs", 64'(out_rs_id), 64'(3));
        chk("p1_addr", 64'(out_result_reg_addr), 64'(7));
        chk("p1_count", 64'(count), 64'(1));
        tick();
        set_in(0, idle, 0, 1); tick();

        // Fill, then drain; the push against a full buffer is refused.
        for (int i = 1; i <= 4; i++) begin
            set_in(1, mk(5'(i), 5'(i), 32'(i), 7'(i)), 0, 0); tick();
        end
        set_in(1, mk(5'd5, 5'd5, 32'd5, 7'd5), 1, 0);
        chk("full_in_ready", 64'(in_ready), 64'(0));
        chk("full_count", 64'(count), 64'(4));
        chk("drain_1", 64'(out_result), 64'(1));
        tick();
        set_in(0, idle, 1, 0);
        chk("after_pop_count", 64'(count), 64'(3));
        chk("after_pop_ready", 64'(in_ready), 64'(1));
        chk("drain_2", 64'(out_result), 64'(2));
        tick();
        set_in(0, idle, 1, 0); chk("drain_3", 64'(out_result), 64'(3)); tick();
        set_in(0, idle, 1, 0); chk("drain_4", 64'(out_result), 64'(4)); tick();
        set_in(0, idle, 1, 0);
        chk("drained_valid", 64'(out_valid), 64'(0));
        chk("drained_count", 64'(count), 64'(0));
        tick();

        // Back-to-back stream of 10 beats across pointer wrap.
        for (int i = 0; i < 10; i++) begin
            set_in(1, mk(5'(i), 5'(i + 1), 32'(100 + i), 7'(i)), 1, 0);
`ifdef RESULT_BUFFER_BYPASS_EN
            chk("stream_valid", 64'(out_valid), 64'(1));
            chk("stream_data", 64'(out_result), 64'(100 + i));
            chk("stream_count", 64'(count), 64'(0));
`else
            if (i > 0) begin
                chk("stream_valid", 64'(out_valid), 64'(1));
                chk("stream_data", 64'(out_result), 64'(100 + i - 1));
                chk("stream_count", 64'(count), 64'(1));
            end
`endif
            tick();
        end
        set_in(0, idle, 1, 0); tick();

        // Flush with simultaneous push and pop.
        set_in(1, mk(5'd1, 5'd1, 32'hA1, 7'd1), 0, 0); tick();
        set_in(1, mk(5'd2, 5'd2, 32'hA2, 7'd2), 0, 0); tick();
        set_in(1, mk(5'd3, 5'd3, 32'hA3, 7'd3), 1, 1);
        chk("flush_count_before", 64'(count), 64'(2));
        chk("flush_out_valid", 64'(out_valid), 64'(0));
        tick();
        set_in(0, idle, 1, 0);
        chk("flush_count", 64'(count), 64'(0));
        chk("flush_valid", 64'(out_valid), 64'(0));
        tick();

        // Empty buffer latency, with or without forwarding.
        set_in(1, mk(5'd9, 5'd9, 32'h12345678, 7'd9), 1, 0);
`ifdef RESULT_BUFFER_BYPASS_EN
        chk("byp_valid", 64'(out_valid), 64'(1));
        chk("byp_data", 64'(out_result), 64'(32'h12345678));
        chk("byp_count", 64'(count), 64'(0));
`else
        chk("nobyp_valid0", 64'(out_valid), 64'(0));
`endif
        tick();
        set_in(0, idle, 1, 0);
`ifdef RESULT_BUFFER_BYPASS_EN
        chk("byp_after_valid", 64'(out_valid), 64'(0));
`else
        chk("nobyp_valid1", 64'(out_valid), 64'(1));
        chk("nobyp_data", 64'(out_result), 64'(32'h12345678));
        chk("nobyp_count", 64'(count), 64'(1));
`endif
        tick();

        // Asynchronous reset in the middle of operation.
        set_in(1, mk(5'd4, 5'd4, 32'hB4, 7'd4), 0, 0); tick();
        set_in(1, mk(5'd5, 5'd5, 32'hB5, 7'd5), 0, 0); tick();
        set_in(0, idle, 0, 0);
        rst = 1'b0;
        #1;
        chk("arst_count", 64'(count), 64'(0));
        chk("arst_valid", 64'(out_valid), 64'(0));
        chk("arst_ready", 64'(in_ready), 64'(1));
        q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Randomized phases biased toward full, balanced and empty.
        for (int p = 0; p < 3; p++) begin
            int piv, pordy;
            piv   = (p == 0) ? 90 : (p == 1) ? 50 : 30;
            pordy = (p == 0) ? 30 : (p == 1) ? 50 : 90;
            for (int c = 0; c < 400; c++) begin
                set_in($urandom_range(0, 99) < piv,
                       mk(5'($urandom), 5'($urandom), $urandom, 7'($urandom)),
                       $urandom_range(0, 99) < pordy,
                       $urandom_range(0, 31) == 0);
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
